chroma_track_ctrl: RTL

//  Frame-level sequencer for the chroma-key detector in the front camera path. It gates the

---
 rtl/chroma_pkg.sv | 28 ++
 rtl/chroma_sample_qual.sv | 43 ++++
 rtl/chroma_track_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/chroma_pkg.sv
// Shared types and helpers for the chroma-key tracking sequencer.
// Holds the sequencer/track state encodings and the centre smoothing filter.
package chroma_pkg;

   localparam int H_BITS = 10;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      SAMPLE,
      EVAL
   } seq_state_t;

   typedef enum logic [1:0] {
      SEARCH,
      LOCK,
      LOST
   } trk_state_t;

   // Weighted 3:1 moving average; 12 bits hold 3*1023+1023 without overflow.
   function automatic logic [H_BITS-1:0] filter_centre(input logic [H_BITS-1:0] prev,
                                                      input logic [H_BITS-1:0] raw);
      logic [11:0] acc;
      acc = ({2'b00, prev} << 1) + {2'b00, prev} + {2'b00, raw};
      return H_BITS'(acc >> 2);
   endfunction

endpackage

// File: rtl/chroma_sample_qual.sv
// Combinational qualification of one detector sample: geometry and staleness
// checks, raw centre and width.
module chroma_sample_qual
   import chroma_pkg::*;
#(
   parameter int MIN_W       = 4,
   parameter int MAX_W       = 320,
   parameter int STALE_LIMIT = 4
) (
   input  logic [H_BITS-1:0] min_x,
   input  logic [H_BITS-1:0] max_x,
   input  logic [H_BITS-1:0] prev_min_x,
   input  logic [H_BITS-1:0] prev_max_x,
   input  logic [3:0]        stale_cnt,
   output logic [3:0]        stale_next,
   output logic              hit,
   output logic [H_BITS-1:0] centre_raw,
   output logic [H_BITS-1:0] width
);

   logic geom_ok;
   logic same_pair;

   assign width      = max_x - min_x;
   assign centre_raw = H_BITS'(({1'b0, min_x} + {1'b0, max_x}) >> 1);

   assign geom_ok = (max_x > min_x) &&
                    (width >= H_BITS'(MIN_W)) &&
                    (width <= H_BITS'(MAX_W));

   assign same_pair = (min_x == prev_min_x) && (max_x == prev_max_x);

   // A frozen detector output repeats the same pair; the count saturates.
   always_comb begin
      stale_next = 4'd0;
      if (same_pair) begin
         stale_next = (stale_cnt == 4'hF) ? stale_cnt : stale_cnt + 4'd1;
      end
   end

   assign hit = geom_ok && ({1'b0, stale_next} < 5'(STALE_LIMIT));

endmodule

// File: rtl/chroma_track_ctrl.sv
// Frame sequencer for the chroma-key detector: gates det_en, samples the
// detector edges after the scan row, tracks the object and publishes results.
module chroma_track_ctrl
   import chroma_pkg::*;
#(
   parameter int SCAN_ROW    = 240,
   parameter int V_ACTIVE    = 480,
   parameter int MIN_W       = 4,
   parameter int MAX_W       = 320,
   parameter int MISS_LIMIT  = 8,
   parameter int STALE_LIMIT = 4,
   parameter int FRAME_DIV   = 1
) (
   input  logic              vga_pclk,
   input  logic              reset_n,
   input  logic              run,
   input  logic              den,
   input  logic [H_BITS-1:0] x_pixel,
   input  logic [H_BITS-1:0] y_pixel,
   input  logic [H_BITS-1:0] chr_min_x,
   input  logic [H_BITS-1:0] chr_max_x,
   output logic              det_en,
   output logic              obj_valid,
   input  logic              obj_ready,
   output logic [H_BITS-1:0] obj_center_x,
   output logic [H_BITS-1:0] obj_width,
   output logic              obj_lock,
   output logic              obj_overrun
);

   // The row just after the scan row, clamped so it always lies in the active area.
   localparam int SAMPLE_ROW_I = (SCAN_ROW + 1 < V_ACTIVE) ? SCAN_ROW + 1 : V_ACTIVE - 1;
   localparam logic [H_BITS-1:0] SAMPLE_ROW = H_BITS'(SAMPLE_ROW_I);

   seq_state_t seq_state, seq_next;
   trk_state_t trk_state, trk_next;

   logic              y_was_nonzero;
   logic              frame_start;
   logic [3:0]        frame_cnt;
   logic [H_BITS-1:0] smp_min, smp_max;
   logic [H_BITS-1:0] prev_min, prev_max;
   logic [3:0]        stale_cnt, stale_next;
   logic [3:0]        miss_cnt, miss_next;
   logic              eval_fire;
   logic              load_raw, load_filt;
   logic              hit;
   logic [H_BITS-1:0] centre_raw, width;
   logic              unused_inputs;

   // The sequencer works on row timing only; den/x_pixel belong to the detector bus.
   assign unused_inputs = &{1'b0, den, x_pixel};

   assign frame_start = (y_pixel == '0) && y_was_nonzero;
   assign eval_fire   = run && (seq_state == EVAL);
   assign det_en      = run && (seq_state == SCAN) && (y_pixel != SAMPLE_ROW);
   assign obj_lock    = (trk_state == LOCK);

   always_ff @(posedge vga_pclk or negedge reset_n) begin
      if (!reset_n) begin
         y_was_nonzero <= 1'b0;
         frame_cnt     <= 4'd0;
      end else begin
         y_was_nonzero <= (y_pixel != '0);
         if (!run) begin
            frame_cnt <= 4'd0;
         end else if (frame_start) begin
            frame_cnt <= (frame_cnt == 4'(FRAME_DIV - 1)) ? 4'd0 : frame_cnt + 4'd1;
         end
      end
   end

   always_ff @(posedge vga_pclk or negedge reset_n) begin
      if (!reset_n) begin
         seq_state <= IDLE;
      end else begin
         seq_state <= seq_next;
      end
   end

   always_comb begin
      seq_next = seq_state;
      case (seq_state)
         IDLE:    if (frame_start && (frame_cnt == 4'd0)) seq_next = SCAN;
         SCAN:    if (y_pixel == SAMPLE_ROW) seq_next = SAMPLE;
         SAMPLE:  seq_next = EVAL;
         EVAL:    seq_next = IDLE;
         default: seq_next = IDLE;
      endcase
      if (!run) begin
         seq_next = IDLE;
      end
   end

   chroma_sample_qual #(
      .MIN_W       (MIN_W),
      .MAX_W       (MAX_W),
      .STALE_LIMIT (STALE_LIMIT)
   ) u_qual (
      .min_x      (smp_min),
      .max_x      (smp_max),
      .prev_min_x (prev_min),
      .prev_max_x (prev_max),
      .stale_cnt  (stale_cnt),
      .stale_next (stale_next),
      .hit        (hit),
      .centre_raw (centre_raw),
      .width      (width)
   );

   always_comb begin
      trk_next  = trk_state;
      miss_next = miss_cnt;
      load_raw  = 1'b0;
      load_filt = 1'b0;
      if (!run) begin
         trk_next  = SEARCH;
         miss_next = 4'd0;
      end else if (eval_fire) begin
         case (trk_state)
            SEARCH, LOST: begin
               if (hit) begin
                  trk_next  = LOCK;
                  load_raw  = 1'b1;
                  miss_next = 4'd0;
               end
            end
            LOCK: begin
               if (hit) begin
                  load_filt = 1'b1;
                  miss_next = 4'd0;
               end else if (miss_cnt == 4'(MISS_LIMIT - 1)) begin
                  trk_next  = LOST;
                  miss_next = 4'd0;
               end else begin
                  miss_next = miss_cnt + 4'd1;
               end
            end
            default: begin
               trk_next  = SEARCH;
               miss_next = 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge vga_pclk or negedge reset_n) begin
      if (!reset_n) begin
         smp_min      <= '0;
         smp_max      <= '0;
         prev_min     <= '0;
         prev_max     <= '0;
         stale_cnt    <= 4'd0;
         trk_state    <= SEARCH;
         miss_cnt     <= 4'd0;
         obj_center_x <= '0;
         obj_width    <= '0;
      end else begin
         trk_state <= trk_next;
         miss_cnt  <= miss_next;
         if (run && (seq_state == SAMPLE)) begin
            smp_min <= chr_min_x;
            smp_max <= chr_max_x;
         end
         if (eval_fire) begin
            prev_min  <= smp_min;
            prev_max  <= smp_max;
            stale_cnt <= stale_next;
         end
         if (load_raw) begin
            obj_center_x <= centre_raw;
            obj_width    <= width;
         end else if (load_filt) begin
            obj_center_x <= filter_centre(obj_center_x, centre_raw);
            obj_width    <= width;
         end
      end
   end

   // A new result always wins; losing an unaccepted one is flagged until run drops.
   always_ff @(posedge vga_pclk or negedge reset_n) begin
      if (!reset_n) begin
         obj_valid   <= 1'b0;
         obj_overrun <= 1'b0;
      end else if (!run) begin
         obj_valid   <= 1'b0;
         obj_overrun <= 1'b0;
      end else if (eval_fire) begin
         obj_valid <= 1'b1;
         if (obj_valid && !obj_ready) begin
            obj_overrun <= 1'b1;
         end
      end else if (obj_valid && obj_ready) begin
         obj_valid <= 1'b0;
      end
   end

endmodule
